// File: rtl/fg_waveform_analyzer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : fg_waveform_analyzer                                            |
// | Brief  : Measures period, on/rise/fall time, peak and edge steps of a    |
// |          strobed unsigned waveform; publishes one set per period.        |
// | Rev    : 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module fg_waveform_analyzer #(
  parameter int COUNTER_BITWIDTH  = 32,
  parameter int WAVEFORM_BITWIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic                         strb_data_valid_i,
  input  logic [WAVEFORM_BITWIDTH-1:0] data_i,
  input  logic [COUNTER_BITWIDTH-1:0]  timeout_i,
  output logic [COUNTER_BITWIDTH-1:0]  period_o,
  output logic [COUNTER_BITWIDTH-1:0]  on_time_o,
  output logic [COUNTER_BITWIDTH-1:0]  rise_time_o,
  output logic [COUNTER_BITWIDTH-1:0]  fall_time_o,
  output logic [WAVEFORM_BITWIDTH-1:0] peak_o,
  output logic [WAVEFORM_BITWIDTH-1:0] k_rise_o,
  output logic [WAVEFORM_BITWIDTH-1:0] k_fall_o,
  output logic                         strb_meas_valid_o,
  output logic                         timeout_o
);

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_ARMED = 3'd1,
    ST_RISE  = 3'd2,
    ST_HIGH  = 3'd3,
    ST_FALL  = 3'd4,
    ST_LOW   = 3'd5
  } state_t;

  localparam logic [COUNTER_BITWIDTH-1:0] c_idx_max = '1;

  state_t                       r_state, w_state_nxt;
  logic [COUNTER_BITWIDTH-1:0]  r_idx, w_idx_nxt, w_idx_inc;
  logic [WAVEFORM_BITWIDTH-1:0] r_prev, w_prev_nxt;
  logic [COUNTER_BITWIDTH-1:0]  r_cap_rise, w_cap_rise_nxt;
  logic [COUNTER_BITWIDTH-1:0]  r_cap_on, w_cap_on_nxt;
  logic [COUNTER_BITWIDTH-1:0]  r_cap_fall, w_cap_fall_nxt;
  logic [WAVEFORM_BITWIDTH-1:0] r_cap_peak, w_cap_peak_nxt;
  logic [WAVEFORM_BITWIDTH-1:0] r_cap_k_rise, w_cap_k_rise_nxt;
  logic [WAVEFORM_BITWIDTH-1:0] r_cap_k_fall, w_cap_k_fall_nxt;
  logic                         w_publish, w_timeout_set, w_rise_start;

  logic [COUNTER_BITWIDTH-1:0]  r_period, r_on_time, r_rise_time, r_fall_time;
  logic [WAVEFORM_BITWIDTH-1:0] r_peak, r_k_rise, r_k_fall;
  logic                         r_meas_valid, r_timeout;

  // Index of the sample currently being accepted; saturates instead of wrapping.
  assign w_idx_inc = (r_idx == c_idx_max) ? r_idx : r_idx + 1'b1;

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_prev_nxt       = r_prev;
    w_cap_rise_nxt   = r_cap_rise;
    w_cap_on_nxt     = r_cap_on;
    w_cap_fall_nxt   = r_cap_fall;
    w_cap_peak_nxt   = r_cap_peak;
    w_cap_k_rise_nxt = r_cap_k_rise;
    w_cap_k_fall_nxt = r_cap_k_fall;
    w_publish        = 1'b0;
    w_timeout_set    = 1'b0;
    w_rise_start     = 1'b0;

    if (!enable_i) begin
      w_state_nxt = ST_SYNC;
      w_idx_nxt   = '0;
    end else if (strb_data_valid_i) begin
      w_prev_nxt = data_i;
      w_idx_nxt  = w_idx_inc;
      if (data_i > r_cap_peak) w_cap_peak_nxt = data_i;

      if ((r_state != ST_SYNC) && (r_state != ST_ARMED) && (w_idx_inc >= timeout_i)) begin
        w_timeout_set    = 1'b1;
        w_state_nxt      = ST_SYNC;
        w_cap_rise_nxt   = '0;
        w_cap_on_nxt     = '0;
        w_cap_fall_nxt   = '0;
        w_cap_peak_nxt   = '0;
        w_cap_k_rise_nxt = '0;
        w_cap_k_fall_nxt = '0;
      end else begin
        case (r_state)
          ST_SYNC: if (data_i == '0) w_state_nxt = ST_ARMED;
          ST_ARMED: if ((data_i != '0) && (r_prev == '0)) w_rise_start = 1'b1;
          ST_RISE: begin
            if (data_i == r_prev) begin
              w_state_nxt    = ST_HIGH;
              w_cap_rise_nxt = w_idx_inc;
            end else if (data_i < r_prev) begin
              w_state_nxt      = ST_FALL;
              w_cap_rise_nxt   = w_idx_inc;
              w_cap_on_nxt     = w_idx_inc;
              w_cap_k_fall_nxt = r_prev - data_i;
            end
          end
          ST_HIGH: begin
            if (data_i < r_prev) begin
              w_state_nxt      = ST_FALL;
              w_cap_on_nxt     = w_idx_inc;
              w_cap_k_fall_nxt = r_prev - data_i;
            end else if (data_i > r_prev) begin
              w_state_nxt = ST_RISE;
            end
          end
          ST_FALL: begin
            if (data_i == '0) begin
              w_state_nxt    = ST_LOW;
              w_cap_fall_nxt = w_idx_inc - r_cap_on;
            end else if (data_i > r_prev) begin
              w_cap_fall_nxt = w_idx_inc - r_cap_on;
              w_publish      = 1'b1;
              w_rise_start   = 1'b1;
            end
          end
          ST_LOW: begin
            if (data_i != '0) begin
              w_publish    = 1'b1;
              w_rise_start = 1'b1;
            end
          end
          default: w_state_nxt = ST_SYNC;
        endcase
      end

      // The terminating sample of one period is the first sample of the next.
      if (w_rise_start) begin
        w_state_nxt      = ST_RISE;
        w_idx_nxt        = '0;
        w_cap_k_rise_nxt = data_i - r_prev;
        w_cap_peak_nxt   = data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_SYNC;
      r_idx        <= '0;
      r_prev       <= '0;
      r_cap_rise   <= '0;
      r_cap_on     <= '0;
      r_cap_fall   <= '0;
      r_cap_peak   <= '0;
      r_cap_k_rise <= '0;
      r_cap_k_fall <= '0;
      r_period     <= '0;
      r_on_time    <= '0;
      r_rise_time  <= '0;
      r_fall_time  <= '0;
      r_peak       <= '0;
      r_k_rise     <= '0;
      r_k_fall     <= '0;
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_prev       <= w_prev_nxt;
      r_cap_rise   <= w_cap_rise_nxt;
      r_cap_on     <= w_cap_on_nxt;
      r_cap_fall   <= w_cap_fall_nxt;
      r_cap_peak   <= w_cap_peak_nxt;
      r_cap_k_rise <= w_cap_k_rise_nxt;
      r_cap_k_fall <= w_cap_k_fall_nxt;
      r_meas_valid <= w_publish;
      if (w_publish) begin
        r_period    <= w_idx_inc;
        r_on_time   <= r_cap_on;
        r_rise_time <= r_cap_rise;
        r_fall_time <= w_cap_fall_nxt;
        r_peak      <= r_cap_peak;
        r_k_rise    <= r_cap_k_rise;
        r_k_fall    <= r_cap_k_fall;
      end
      if (!enable_i)          r_timeout <= 1'b0;
      else if (w_timeout_set) r_timeout <= 1'b1;
    end
  end

  assign period_o          = r_period;
  assign on_time_o         = r_on_time;
  assign rise_time_o       = r_rise_time;
  assign fall_time_o       = r_fall_time;
  assign peak_o            = r_peak;
  assign k_rise_o          = r_k_rise;
  assign k_fall_o          = r_k_fall;
  assign strb_meas_valid_o = r_meas_valid;
  assign timeout_o         = r_timeout;

endmodule
`default_nettype wire
